univ_shift_reg: RTL and testbench

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

---
 rtl/univ_shift_reg.sv | 56 +++++
 tb/tb_univ_shift_reg.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right/left and parallel load.
// Counts shifts per word and pulses word_valid when a word completes.
module univ_shift_reg #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                       Clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [1:0]                 mode,
  input  logic                       sin,
  input  logic [WIDTH-1:0]           pin,
  output logic [WIDTH-1:0]           q,
  output logic                       sout,
  output logic [$clog2(WIDTH)-1:0]   bit_cnt,
  output logic                       word_valid
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic shift;
  logic wrap;

  assign shift = en && (mode == 2'b01 || mode == 2'b10);
  assign wrap  = shift && (bit_cnt == LAST);
  assign sout  = (mode == 2'b10) ? q[WIDTH-1] : q[0];

  always_ff @(posedge Clk) begin
    if (rst) begin
      q          <= RST_VAL;
      bit_cnt    <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= wrap;
      if (en) begin
        unique case (mode)
          2'b00: q <= q;
          2'b01: q <= {sin, q[WIDTH-1:1]};
          2'b10: q <= {q[WIDTH-2:0], sin};
          2'b11: q <= pin;
          default: q <= q;
        endcase
      end
      // Non-power-of-two widths need an explicit wrap point.
      if (en && mode == 2'b11) begin
        bit_cnt <= '0;
      end else if (wrap) begin
        bit_cnt <= '0;
      end else if (shift) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed and random stimulus for univ_shift_reg (WIDTH=8),
// checked against an arithmetic reference model.
module tb_univ_shift_reg;

  logic       Clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       sin = 1'b0;
  logic [7:0] pin = 8'h00;
  logic [7:0] q;
  logic       sout;
  logic [2:0] bit_cnt;
  logic       word_valid;

  int checks = 0;
  int errors = 0;
  int mq = 0;
  int mcnt = 0;
  int mwv = 0;
  bit ready = 1'b0;
  int wv_seen;

  univ_shift_reg #(.WIDTH(8), .RST_VAL(8'h00)) dut (
    .Clk(Clk), .rst(rst), .en(en), .mode(mode), .sin(sin),
    .pin(pin), .q(q), .sout(sout), .bit_cnt(bit_cnt),
    .word_valid(word_valid)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic r, input logic e,
                       input logic [1:0] m, input logic s,
                       input logic [7:0] p);
    if (r) begin
      mq = 0; mcnt = 0; mwv = 0;
    end else begin
      mwv = 0;
      if (e) begin
        if (m == 2'b11) begin
          mq = p; mcnt = 0;
        end else if (m != 2'b00) begin
          if (m == 2'b01) mq = (mq / 2) + (s ? 128 : 0);
          else mq = ((mq * 2) % 256) + (s ? 1 : 0);
          mcnt = (mcnt + 1) % 8;
          mwv = (mcnt == 0) ? 1 : 0;
        end
      end
    end
  endtask

  task automatic cyc(input logic r, input logic e, input logic [1:0] m,
                     input logic s, input logic [7:0] p);
    int exp_sout;
    rst = r; en = e; mode = m; sin = s; pin = p;
    #1;
    if (ready) begin
      exp_sout = (m == 2'b10) ? (mq / 128) % 2 : mq % 2;
      chk("sout", 32'(sout), 32'(exp_sout));
    end
    @(posedge Clk);
    model(r, e, m, s, p);
    #1;
    if (r) ready = 1'b1;
    chk("q", 32'(q), 32'(mq));
    chk("bit_cnt", 32'(bit_cnt), 32'(mcnt));
    chk("word_valid", 32'(word_valid), 32'(mwv));
  endtask

  initial begin
    logic [7:0] sipo;
    logic [7:0] piso;
    sipo = 8'b0100_1101;
    piso = 8'hA5;
    #2;
    cyc(1, 1, 2'b11, 1, 8'hFF);
    chk("reset_q", 32'(q), 32'h00);
    chk("reset_wv", 32'(word_valid), 32'h0);

    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 2'b01, sipo[i], 8'hFF);
      if (i < 7) chk("sipo_wv_low", 32'(word_valid), 32'h0);
    end
    chk("sipo_q", 32'(q), 32'h4D);
    chk("sipo_cnt", 32'(bit_cnt), 32'h0);
    chk("sipo_wv", 32'(word_valid), 32'h1);
    cyc(0, 1, 2'b00, 1, 8'hFF);
    chk("sipo_wv_drop", 32'(word_valid), 32'h0);

    cyc(0, 1, 2'b11, 1, 8'hA5);
    for (int i = 7; i >= 0; i--) begin
      rst = 0; en = 1; mode = 2'b10; sin = 0;
      #1;
      chk("piso_sout", 32'(sout), 32'(piso[i]));
      cyc(0, 1, 2'b10, 0, 8'h5A);
    end
    chk("piso_q", 32'(q), 32'h00);
    chk("piso_wv", 32'(word_valid), 32'h1);

    wv_seen = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 2'b01, 1'(i), 8'h00);
      wv_seen += word_valid;
      cyc(0, 0, 2'b01, 1, 8'hFF);
      wv_seen += word_valid;
      cyc(0, 0, 2'b11, 0, 8'hC3);
      wv_seen += word_valid;
    end
    chk("gap_pulses", 32'(wv_seen), 32'd1);

    for (int i = 0; i < 3; i++) cyc(0, 1, 2'b01, 1, 8'h00);
    cyc(1, 1, 2'b01, 1, 8'h00);
    chk("rst_mid_q", 32'(q), 32'h00);
    chk("rst_mid_cnt", 32'(bit_cnt), 32'h0);
    for (int i = 0; i < 7; i++) cyc(0, 1, 2'b01, 1, 8'h00);
    chk("rst_mid_no_wv", 32'(word_valid), 32'h0);
    cyc(0, 1, 2'b01, 1, 8'h00);
    chk("rst_mid_wv", 32'(word_valid), 32'h1);

    for (int i = 0; i < 5; i++) cyc(0, 1, 2'b10, 0, 8'h00);
    cyc(0, 1, 2'b11, 1, 8'h3C);
    chk("load_mid_q", 32'(q), 32'h3C);
    chk("load_mid_cnt", 32'(bit_cnt), 32'h0);
    chk("load_mid_wv", 32'(word_valid), 32'h0);

    for (int i = 0; i < 4; i++) cyc(0, 1, 2'b01, 1'(i % 2), 8'h00);
    chk("dir_cnt4", 32'(bit_cnt), 32'h4);
    for (int i = 0; i < 4; i++) cyc(0, 1, 2'b10, 1'(i < 2), 8'h00);
    chk("dir_cnt", 32'(bit_cnt), 32'h0);
    chk("dir_wv", 32'(word_valid), 32'h1);

    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 3) != 0),
          2'($urandom), 1'($urandom), 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
